// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - shared constants for the CPU data-bus bridge
// Contents: peripheral window base, peripheral register offsets,
// active-low 7-segment glyph table (bit0..6 = a..g, bit7 = dp, dp off).
package bridge_pkg;

  localparam logic [19:0] PERIPH_BASE = 20'hFFFFF;

  localparam logic [11:0] ADDR_SEG   = 12'h000;
  localparam logic [11:0] ADDR_TIMER = 12'h020;
  localparam logic [11:0] ADDR_LED   = 12'h060;
  localparam logic [11:0] ADDR_SW    = 12'h070;
  localparam logic [11:0] ADDR_BTN   = 12'h078;

  // Entry n is the glyph for hex digit n; listed from F down to 0.
  localparam logic [15:0][7:0] GLYPH_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] glyph(input logic [3:0] nib);
    return GLYPH_TABLE[nib];
  endfunction

endpackage

// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 8-digit 7-segment scanner
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   seg     in   32-bit display value, nibble k shown on digit k
//   dig_en  out  registered digit enables, active-low
//   dn_seg  out  registered segment pattern, active-low, dp off
module seg_scan
  import bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seg,
  output logic [7:0]  dig_en,
  output logic [7:0]  dn_seg
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    idx;

  // Outputs are registered from the current idx/seg, so they trail a
  // digit step or a SEG write by one edge; the scan itself never restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= 3'd0;
      dig_en   <= 8'hFE;
      dn_seg   <= 8'hC0;
    end else begin
      if (scan_cnt == CNT_MAX) begin
        scan_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      dig_en <= ~(8'b1 << idx);
      dn_seg <= glyph(seg[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/bus_bridge.sv
// rtl/bus_bridge.sv - CPU data-bus bridge: data RAM / peripheral decode
// Optional feature macro: BRIDGE_TIMER_EN (free-running timer at 0x020).
// Ports:
//   cpu_clk     in   system clock
//   cpu_rst     in   asynchronous active-low reset
//   Bus_addr    in   CPU byte address
//   Bus_we      in   CPU write strobe
//   Bus_wdata   in   CPU write data
//   Bus_rdata   out  combinational read data
//   dram_addr   out  RAM word address
//   dram_we     out  RAM write enable
//   dram_wdata  out  RAM write data
//   dram_rdata  in   RAM asynchronous read data
//   sw          in   raw switches
//   button      in   raw buttons
//   led         out  LED register
//   dig_en      out  digit enables, active-low
//   dn_seg      out  segments, active-low
module bus_bridge
  import bridge_pkg::*;
#(
  parameter int DRAM_AW  = 16,
  parameter int SCAN_DIV = 20000
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_we,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_we,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         button,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dn_seg
);

  logic        periph_hit;
  logic [11:0] offset;
  logic        periph_we;
  logic [31:0] seg_reg;
  logic [23:0] sw_meta, sw_sync;
  logic [4:0]  btn_meta, btn_sync;
  logic [31:0] periph_rdata;

  assign periph_hit = (Bus_addr[31:12] == PERIPH_BASE);
  assign offset     = Bus_addr[11:0];
  assign periph_we  = Bus_we & periph_hit;

  // Gating with cpu_rst keeps the RAM from being written while reset is held.
  assign dram_we    = Bus_we & ~periph_hit & cpu_rst;
  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wdata = Bus_wdata;

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led      <= '0;
      seg_reg  <= '0;
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= button;
      btn_sync <= btn_meta;
      if (periph_we && offset == ADDR_LED) led     <= Bus_wdata[23:0];
      if (periph_we && offset == ADDR_SEG) seg_reg <= Bus_wdata;
    end
  end

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer;

  // A CPU write wins over the increment on the same edge.
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      timer <= '0;
    end else if (periph_we && offset == ADDR_TIMER) begin
      timer <= Bus_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  always_comb begin
    periph_rdata = '0;
    case (offset)
      ADDR_SEG:   periph_rdata = seg_reg;
      ADDR_LED:   periph_rdata = {8'h00, led};
      ADDR_SW:    periph_rdata = {8'h00, sw_sync};
      ADDR_BTN:   periph_rdata = {27'h0, btn_sync};
`ifdef BRIDGE_TIMER_EN
      ADDR_TIMER: periph_rdata = timer;
`endif
      default:    periph_rdata = '0;
    endcase
  end

  assign Bus_rdata = periph_hit ? periph_rdata : dram_rdata;

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clk    (cpu_clk),
    .rst_n  (cpu_rst),
    .seg    (seg_reg),
    .dig_en (dig_en),
    .dn_seg (dn_seg)
  );

endmodule

// File: tb/tb_bus_bridge.sv
// tb/tb_bus_bridge.sv - scoreboard bench for bus_bridge with reference model
module tb_bus_bridge;

  localparam int DRAM_AW  = 16;
  localparam int SCAN_DIV = 4;

  logic               cpu_clk = 1'b0;
  logic               cpu_rst = 1'b0;
  logic [31:0]        Bus_addr = '0;
  logic               Bus_we = 1'b0;
  logic [31:0]        Bus_wdata = '0;
  logic [31:0]        Bus_rdata;
  logic [DRAM_AW-1:0] dram_addr;
  logic               dram_we;
  logic [31:0]        dram_wdata;
  logic [31:0]        dram_rdata = '0;
  logic [23:0]        sw = '0;
  logic [4:0]         button = '0;
  logic [23:0]        led;
  logic [7:0]         dig_en;
  logic [7:0]         dn_seg;

  bus_bridge #(
    .DRAM_AW  (DRAM_AW),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .Bus_addr   (Bus_addr),
    .Bus_we     (Bus_we),
    .Bus_wdata  (Bus_wdata),
    .Bus_rdata  (Bus_rdata),
    .dram_addr  (dram_addr),
    .dram_we    (dram_we),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .button     (button),
    .led        (led),
    .dig_en     (dig_en),
    .dn_seg     (dn_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [23:0] led;
    logic [7:0]  dig;
    logic [7:0]  seg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   txn_id   = 0;

  // Standard hex digits, active-low, dp off.
  logic [7:0] glyph_m [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state (register contents after the last counted edge).
  logic [23:0] led_m;
  logic [31:0] seg_m, prev_seg_m, tload_val;
  int unsigned edges, tload_e;
  logic [23:0] sw_hist[$];
  logic [4:0]  btn_hist[$];

  function automatic void model_reset();
    led_m = '0; seg_m = '0; prev_seg_m = '0;
    tload_val = '0; tload_e = 0; edges = 0;
    sw_hist.delete(); btn_hist.delete();
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] r;
    if (a[31:12] != 20'hFFFFF) return rd;
    r = 32'h0;
    case (a[11:0])
      12'h000: r = seg_m;
      12'h060: r = {8'h0, led_m};
      12'h070: r = (sw_hist.size() >= 2) ? {8'h0, sw_hist[sw_hist.size()-2]} : 32'h0;
      12'h078: r = (btn_hist.size() >= 2) ? {27'h0, btn_hist[btn_hist.size()-2]} : 32'h0;
`ifdef BRIDGE_TIMER_EN
      12'h020: r = tload_val + 32'(edges - tload_e);
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic do_cycle(input logic rst, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input logic [23:0] sw_v, input logic [4:0] btn_v);
    exp_t e;
    int   pos;
    cpu_rst = rst; Bus_we = we; Bus_addr = a; Bus_wdata = wd;
    dram_rdata = rd; sw = sw_v; button = btn_v;
    if (!rst) model_reset();
    e.id    = txn_id++;
    e.rdata = model_read(a, rd);
    e.we    = we & rst & (a[31:12] != 20'hFFFFF);
    e.addr  = a[17:2];
    e.wdata = wd;
    e.led   = led_m;
    if (edges == 0) begin
      e.dig = 8'hFE;
      e.seg = 8'hC0;
    end else begin
      pos   = int'(((edges - 1) / SCAN_DIV) % 8);
      e.dig = ~(8'h01 << pos);
      e.seg = glyph_m[(prev_seg_m >> (4 * pos)) & 32'hF];
    end
    sb_q.push_back(e);
    if (rst) begin
      prev_seg_m = seg_m;
      sw_hist.push_back(sw_v);
      btn_hist.push_back(btn_v);
      if (sw_hist.size() > 2) void'(sw_hist.pop_front());
      if (btn_hist.size() > 2) void'(btn_hist.pop_front());
      if (we && a[31:12] == 20'hFFFFF) begin
        if (a[11:0] == 12'h060) led_m = wd[23:0];
        if (a[11:0] == 12'h000) seg_m = wd;
        if (a[11:0] == 12'h020) begin tload_val = wd; tload_e = edges + 1; end
      end
      edges++;
    end
    @(negedge cpu_clk);
  endtask

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s txn %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compares every presented bus cycle just before the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rdata",      e.id, Bus_rdata,  e.rdata);
        chk("dram_we",    e.id, {31'h0, dram_we}, {31'h0, e.we});
        chk("dram_addr",  e.id, {16'h0, dram_addr}, {16'h0, e.addr});
        chk("dram_wdata", e.id, dram_wdata, e.wdata);
        chk("led",        e.id, {8'h0, led}, {8'h0, e.led});
        chk("dig_en",     e.id, {24'h0, dig_en}, {24'h0, e.dig});
        chk("dn_seg",     e.id, {24'h0, dn_seg}, {24'h0, e.seg});
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 8))
      0: a = 32'hFFFFF000;
      1: a = 32'hFFFFF060;
      2: a = 32'hFFFFF070;
      3: a = 32'hFFFFF078;
      4: a = 32'hFFFFF020;
      5: a = 32'hFFFFF000 | ($urandom & 32'hFFF);
      6: a = 32'hFFFFF061;
      default: a = $urandom & 32'h7FFFFFFF;
    endcase
    return a;
  endfunction

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [23:0] sw_r;
    logic [4:0]  btn_r;
    model_reset();
    @(negedge cpu_clk);
    // Held in reset: a RAM write must not reach dram_we.
    do_cycle(0, 1, 32'h00000040, 32'hDEADBEEF, 32'h0, 24'h0, 5'h0);
    do_cycle(0, 0, 32'hFFFFF000, 32'h0, 32'h0, 24'h0, 5'h0);
    do_cycle(1, 0, 32'hFFFFF000, 32'h0, 32'h0, 24'h0, 5'h0);
    // LED write / read.
    do_cycle(1, 1, 32'hFFFFF060, 32'h00ABCDEF, 32'h0, 24'h0, 5'h0);
    do_cycle(1, 0, 32'hFFFFF060, 32'h0, 32'h0, 24'h0, 5'h0);
    // RAM write with same-cycle read data.
    do_cycle(1, 1, 32'h00000010, 32'hCAFEF00D, 32'h12345678, 24'h0, 5'h0);
    // Switch synchroniser latency and ignored RO write.
    for (int i = 0; i < 4; i++)
      do_cycle(1, 0, 32'hFFFFF070, 32'h0, 32'h0, 24'h00F00F, 5'h0);
    do_cycle(1, 1, 32'hFFFFF070, 32'hFFFFFFFF, 32'h0, 24'h00F00F, 5'h1F);
    for (int i = 0; i < 3; i++)
      do_cycle(1, 0, 32'hFFFFF078, 32'h0, 32'h0, 24'h00F00F, 5'h1F);
    // Timer load and wrap (reads 0 when the timer is not built).
    do_cycle(1, 1, 32'hFFFFF020, 32'hFFFFFFFE, 32'h0, 24'h0, 5'h0);
    for (int i = 0; i < 3; i++)
      do_cycle(1, 0, 32'hFFFFF020, 32'h0, 32'h0, 24'h0, 5'h0);
    // Full display scan of 76543210.
    do_cycle(1, 1, 32'hFFFFF000, 32'h76543210, 32'h0, 24'h0, 5'h0);
    for (int i = 0; i < 8 * SCAN_DIV + 6; i++)
      do_cycle(1, 0, 32'hFFFFF000, 32'h0, 32'h0, 24'h0, 5'h0);
    // Randomised traffic with a reset pulse in the middle.
    for (int i = 0; i < 600; i++) begin
      sw_r  = 24'($urandom);
      btn_r = 5'($urandom);
      if (i >= 300 && i < 303)
        do_cycle(0, 1'($urandom), rand_addr(), $urandom, $urandom, sw_r, btn_r);
      else
        do_cycle(1, ($urandom_range(0, 2) == 0), rand_addr(), $urandom, $urandom, sw_r, btn_r);
    end
    Bus_we = 1'b0;
    repeat (3) @(negedge cpu_clk);
    chk("sb_drain", 0, 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
